// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_scan_controller_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIG_W      = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StShow  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/display_scan_controller_if.sv
// Display-side bundle: scan controls in, selected digit data out.
interface display_scan_controller_if
    import display_scan_controller_pkg::*;
();

    logic             en;
    logic [15:0]      value;
    logic [3:0]       dp_in;
    logic             lz_en;
    logic [DIG_W-1:0] dig_sel;
    logic [3:0]       nibble;
    logic             dp;
    logic             blank;
    logic             frame_start;

    modport master (
        output en, value, dp_in, lz_en,
        input  dig_sel, nibble, dp, blank, frame_start
    );

    modport slave (
        input  en, value, dp_in, lz_en,
        output dig_sel, nibble, dp, blank, frame_start
    );

endinterface

// File: rtl/display_scan_controller_lz_blanker.sv
// Leading-zero suppression: blanks digit n (n>0) when nibbles n..3 are all zero.
module display_scan_controller_lz_blanker
    import display_scan_controller_pkg::*;
(
    input  logic [15:0]      value_i,
    input  logic             lz_en_i,
    input  logic [DIG_W-1:0] dig_sel_i,
    output logic             blank_req_o
);

    always_comb begin
        blank_req_o = 1'b0;
        if (lz_en_i && (dig_sel_i != '0)) begin
            blank_req_o = 1'b1;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if ((i >= int'(dig_sel_i)) && (value_i[4*i +: 4] != 4'h0)) begin
                    blank_req_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit time-multiplexed scan engine with per-digit dead-time and per-frame snapshot.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    display_scan_controller_if.slave    bus
);

    localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYCLES == 0 ? 0 : BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ShowLast  = CNT_W'(CLK_DIV == 0 ? 0 : CLK_DIV - 1);
    localparam logic [DIG_W-1:0] LastDig   = DIG_W'(NUM_DIGITS - 1);
    localparam scan_state_e      AfterShow = (BLANK_CYCLES == 0) ? StShow : StBlank;

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic [15:0]      snap_val_q, snap_val_d;
    logic [3:0]       snap_dp_q, snap_dp_d;
    logic [3:0]       nibble_q, nibble_d;
    logic             dp_q, dp_d;
    logic             blank_q, blank_d;
    logic             fs_q, fs_d;
    logic             frame_entry;
    logic             lz_req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dig_d       = dig_q;
        snap_val_d  = snap_val_q;
        snap_dp_d   = snap_dp_q;
        frame_entry = 1'b0;
        if (!bus.en) begin
            state_d = StIdle;
            cnt_d   = '0;
            dig_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    frame_entry = 1'b1;
                    dig_d       = '0;
                    cnt_d       = '0;
                    state_d     = AfterShow;
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StShow: begin
                    if (cnt_q == ShowLast) begin
                        cnt_d       = '0;
                        dig_d       = dig_q + DIG_W'(1);
                        frame_entry = (dig_q == LastDig);
                        state_d     = AfterShow;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (frame_entry) begin
            snap_val_d = bus.value;
            snap_dp_d  = bus.dp_in;
        end
    end

    // Fed from next-state values so blank/dp/nibble can be registered without extra latency.
    display_scan_controller_lz_blanker u_lz_blanker (
        .value_i     (snap_val_d),
        .lz_en_i     (bus.lz_en),
        .dig_sel_i   (dig_d),
        .blank_req_o (lz_req)
    );

    always_comb begin
        blank_d  = (state_d != StShow) || lz_req;
        nibble_d = (state_d == StIdle) ? 4'h0 : snap_val_d[{dig_d, 2'b00} +: 4];
        dp_d     = snap_dp_d[dig_d] & ~blank_d;
        fs_d     = frame_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dig_q      <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            nibble_q   <= '0;
            dp_q       <= 1'b0;
            blank_q    <= 1'b1;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
            snap_val_q <= snap_val_d;
            snap_dp_q  <= snap_dp_d;
            nibble_q   <= nibble_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.dig_sel     = dig_q;
    assign bus.nibble      = nibble_q;
    assign bus.dp          = dp_q;
    assign bus.blank       = blank_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge monitor pops and checks.
module tb_display_scan_controller;

    typedef struct packed {
        logic       fs;
        logic       blank;
        logic       dp;
        logic [1:0] dig;
        logic [3:0] nib;
    } exp_t;

    localparam int BC_A = 2;
    localparam int CD_A = 4;
    localparam int BC_B = 0;
    localparam int CD_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scan_controller_if if_a ();
    display_scan_controller_if if_b ();

    display_scan_controller #(
        .CLK_DIV      (CD_A),
        .BLANK_CYCLES (BC_A),
        .CNT_W        (16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    display_scan_controller #(
        .CLK_DIV      (CD_B),
        .BLANK_CYCLES (BC_B),
        .CNT_W        (4)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rec_a    = 0;
    int   rec_b    = 0;
    logic end_req  = 1'b0;
    logic end_done = 1'b0;

    task automatic push(input bit sel, input logic [1:0] dig, input logic [3:0] nib,
                        input logic dp, input logic blank, input logic fs);
        exp_t e;
        e = '{fs: fs, blank: blank, dp: dp, dig: dig, nib: nib};
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    task automatic push_idle(input bit sel, input int n);
        for (int i = 0; i < n; i++) push(sel, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    endtask

    // One digit slot: bc dead-time cycles then cd lit cycles.
    task automatic push_digit(input bit sel, input int bc, input int cd, input logic [1:0] dig,
                              input logic [3:0] nib, input logic show_blank, input logic dpv,
                              input logic fs);
        for (int i = 0; i < bc; i++) push(sel, dig, nib, 1'b0, 1'b1, fs && (i == 0));
        for (int i = 0; i < cd; i++)
            push(sel, dig, nib, dpv & ~show_blank, show_blank, fs && (bc == 0) && (i == 0));
    endtask

    task automatic push_frame_a(input logic [3:0] n3, input logic [3:0] n2, input logic [3:0] n1,
                                input logic [3:0] n0, input logic [3:0] lzb);
        push_digit(1'b0, BC_A, CD_A, 2'd0, n0, lzb[0], 1'b0, 1'b1);
        push_digit(1'b0, BC_A, CD_A, 2'd1, n1, lzb[1], 1'b0, 1'b0);
        push_digit(1'b0, BC_A, CD_A, 2'd2, n2, lzb[2], 1'b0, 1'b0);
        push_digit(1'b0, BC_A, CD_A, 2'd3, n3, lzb[3], 1'b0, 1'b0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        if (q_a.size() > 0) begin
            e   = q_a.pop_front();
            act = '{fs: if_a.frame_start, blank: if_a.blank, dp: if_a.dp,
                    dig: if_a.dig_sel, nib: if_a.nibble};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL dut_a rec %0d: got fs=%b blank=%b dp=%b dig=%0d nib=%h, want fs=%b blank=%b dp=%b dig=%0d nib=%h",
                         rec_a, act.fs, act.blank, act.dp, act.dig, act.nib,
                         e.fs, e.blank, e.dp, e.dig, e.nib);
            end
            rec_a++;
        end
        if (q_b.size() > 0) begin
            e   = q_b.pop_front();
            act = '{fs: if_b.frame_start, blank: if_b.blank, dp: if_b.dp,
                    dig: if_b.dig_sel, nib: if_b.nibble};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL dut_b rec %0d: got fs=%b blank=%b dp=%b dig=%0d nib=%h, want fs=%b blank=%b dp=%b dig=%0d nib=%h",
                         rec_b, act.fs, act.blank, act.dp, act.dig, act.nib,
                         e.fs, e.blank, e.dp, e.dig, e.nib);
            end
            rec_b++;
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            n_checks++;
            if ((q_a.size() + q_b.size()) != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d expected records left, want 0",
                         q_a.size() + q_b.size());
            end
        end
    end

    initial begin
        if_a.en = 1'b0; if_a.value = 16'h0; if_a.dp_in = 4'h0; if_a.lz_en = 1'b0;
        if_b.en = 1'b0; if_b.value = 16'h0; if_b.dp_in = 4'h0; if_b.lz_en = 1'b0;

        // Reset held 3 cycles, then reset values on both instances.
        cycles(3);
        rst = 1'b0;
        push_idle(1'b1, 1);

        // First frames of 1234: frame_start every 24 cycles.
        if_a.en = 1'b1; if_a.value = 16'h1234; if_a.lz_en = 1'b0;
        push_idle(1'b0, 1);
        push_frame_a(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);
        push_frame_a(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);
        cycles(49);

        // Leading zeros on 0070.
        if_a.en = 1'b0;
        push(1'b0, 2'd0, 4'h4, 1'b0, 1'b1, 1'b1);
        cycles(1);
        if_a.en = 1'b1; if_a.value = 16'h0070; if_a.lz_en = 1'b1;
        push_idle(1'b0, 1);
        push_frame_a(4'h0, 4'h0, 4'h7, 4'h0, 4'b1100);
        cycles(25);

        // All zeros: only digit 0 lit.
        if_a.en = 1'b0;
        push(1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1);
        cycles(1);
        if_a.en = 1'b1; if_a.value = 16'h0000;
        push_idle(1'b0, 1);
        push_frame_a(4'h0, 4'h0, 4'h0, 4'h0, 4'b1110);
        cycles(25);

        // Snapshot integrity: value changes during digit-1 SHOW.
        if_a.en = 1'b0;
        push(1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1);
        cycles(1);
        if_a.en = 1'b1; if_a.value = 16'hAAAA; if_a.lz_en = 1'b0;
        push_idle(1'b0, 1);
        push_frame_a(4'hA, 4'hA, 4'hA, 4'hA, 4'b0000);
        push_frame_a(4'h5, 4'h5, 4'h5, 4'h5, 4'b0000);
        cycles(10);
        if_a.value = 16'h5555;
        cycles(39);

        // en drop during digit-2 SHOW, then restart.
        if_a.en = 1'b0;
        push(1'b0, 2'd0, 4'h5, 1'b0, 1'b1, 1'b1);
        cycles(1);
        if_a.en = 1'b1; if_a.value = 16'h1234;
        push_idle(1'b0, 1);
        push_digit(1'b0, BC_A, CD_A, 2'd0, 4'h4, 1'b0, 1'b0, 1'b1);
        push_digit(1'b0, BC_A, CD_A, 2'd1, 4'h3, 1'b0, 1'b0, 1'b0);
        push_digit(1'b0, BC_A, 2,    2'd2, 4'h2, 1'b0, 1'b0, 1'b0);
        cycles(17);
        if_a.en = 1'b0;
        push(1'b0, 2'd2, 4'h2, 1'b0, 1'b0, 1'b0);
        cycles(1);
        if_a.en = 1'b1;
        push_idle(1'b0, 1);
        push_frame_a(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);
        cycles(25);

        // Reset pulse while digit 3 is lit.
        push_digit(1'b0, BC_A, CD_A, 2'd0, 4'h4, 1'b0, 1'b0, 1'b1);
        push_digit(1'b0, BC_A, CD_A, 2'd1, 4'h3, 1'b0, 1'b0, 1'b0);
        push_digit(1'b0, BC_A, CD_A, 2'd2, 4'h2, 1'b0, 1'b0, 1'b0);
        push_digit(1'b0, BC_A, 1,    2'd3, 4'h1, 1'b0, 1'b0, 1'b0);
        cycles(21);
        rst = 1'b1;
        push(1'b0, 2'd3, 4'h1, 1'b0, 1'b0, 1'b0);
        cycles(1);
        rst = 1'b0; if_a.en = 1'b0;
        push_idle(1'b0, 3);
        cycles(3);

        // Zero dead-time, one cycle per digit, dp on digit 2 only.
        if_b.en = 1'b1; if_b.value = 16'h4321; if_b.dp_in = 4'b0100; if_b.lz_en = 1'b0;
        push_idle(1'b1, 1);
        for (int f = 0; f < 2; f++) begin
            push_digit(1'b1, BC_B, CD_B, 2'd0, 4'h1, 1'b0, 1'b0, 1'b1);
            push_digit(1'b1, BC_B, CD_B, 2'd1, 4'h2, 1'b0, 1'b0, 1'b0);
            push_digit(1'b1, BC_B, CD_B, 2'd2, 4'h3, 1'b0, 1'b1, 1'b0);
            push_digit(1'b1, BC_B, CD_B, 2'd3, 4'h4, 1'b0, 1'b0, 1'b0);
        end
        cycles(9);
        if_b.en = 1'b0;
        push(1'b1, 2'd0, 4'h1, 1'b0, 1'b0, 1'b1);
        cycles(1);
        push_idle(1'b1, 1);
        cycles(1);

        end_req = 1'b1;
        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
